rggen_register_initiator: RTL and testbench
===========================================

RGGEN_REGISTER_INITIATOR -- requirements
Module: rggen_register_initiator

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 8: byte-address width of the request and register sides.
REQ-002 SHALL have parameter BUS_WIDTH, default 32: data width in bits, a multiple of 8.
REQ-003 SHALL have parameter REGISTERS, default 1: number of attached register responders, at least 1.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 16: BUSY-cycle limit, at least 2, used only when timeout is compiled in.
REQ-005 SHALL have port i_clk, input, 1: single clock; all state changes on its rising edge.
REQ-006 SHALL have port i_rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have ports i_request_valid, input, 1, and o_request_ready, output, 1: host request handshake.
REQ-008 SHALL have port i_request_access, input, 2: bit0=1 is a write, bit0=0 is a read.
REQ-009 SHALL have ports i_request_address, input, ADDRESS_WIDTH, and i_request_write_data, input, BUS_WIDTH: request address and write data.
REQ-010 SHALL have port i_request_strobe, input, BUS_WIDTH/8: per-byte write enable.
REQ-011 SHALL have ports o_response_valid, output, 1, and i_response_ready, input, 1: response handshake.
REQ-012 SHALL have ports o_response_status, output, 2, and o_response_read_data, output, BUS_WIDTH: response payload.
REQ-013 SHALL have ports o_register_valid, output, 1; o_register_access, output, 2; o_register_address, output, ADDRESS_WIDTH; o_register_write_data, output, BUS_WIDTH; o_register_strobe, output, BUS_WIDTH (bit mask): register-side request.
REQ-014 SHALL have ports i_register_active, input, REGISTERS; i_register_ready, input, REGISTERS; i_register_status, input, 2*REGISTERS; i_register_read_data, input, BUS_WIDTH*REGISTERS: per-register response, entry k at slice k.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY and RESPONSE.
REQ-016 SHALL drive o_request_ready=1 only in IDLE; a request is accepted when i_request_valid=1 and o_request_ready=1, moving IDLE->BUSY.
REQ-017 SHALL capture access, address, write data and strobe on acceptance and hold them stable until the next acceptance.
REQ-018 SHALL expand strobe byte b into o_register_strobe bits [8b+7:8b].
REQ-019 SHALL drive o_register_valid=1 exactly while in BUSY, so it is first asserted the cycle after acceptance.
REQ-020 SHALL complete in BUSY with status 2'b11 (decode error) and read data 0 when i_register_active is all zero.
REQ-021 SHALL otherwise complete in BUSY when any bit of (i_register_active & i_register_ready) is set, taking status and read data as the bitwise OR over those selected entries.
REQ-022 SHALL, on completion, register status and read data, move BUSY->RESPONSE and deassert o_register_valid the next cycle.
REQ-023 SHALL, in RESPONSE, hold o_response_valid=1 with stable payload until i_response_ready=1, then move to IDLE.
REQ-024 SHALL NOT accept a new request in the same cycle a response handshake completes; minimum spacing is 3 cycles per transaction.
REQ-025 SHALL keep o_response_read_data 0 for write accesses.

Reset
REQ-026 SHALL, on i_rst_n=0 at any time including mid-transaction, enter IDLE and abandon the in-flight request.
REQ-027 SHALL reset outputs as: o_request_ready=1 after reset release; o_register_valid=0; o_response_valid=0; o_response_status=0; o_response_read_data=0; captured request registers and timeout counter=0.

Configuration
REQ-028 SHALL, with macro RGGEN_INITIATOR_TIMEOUT_EN defined, count BUSY cycles from 0 and complete with status 2'b10 (slave error), read data 0, if no completion occurs by count TIMEOUT_CYCLES-1.
REQ-029 SHALL give a completion (REQ-020/021) priority over a timeout occurring in the same cycle.
REQ-030 SHALL, without RGGEN_INITIATOR_TIMEOUT_EN, contain no counter and wait in BUSY indefinitely.

Verification
REQ-031 SHALL cover: write 0xA5A5_0000 to addr 0x04 with strobe 0xC, reg0 active and ready on the first BUSY cycle -> o_register_strobe=0xFFFF_0000, then response status 00.
REQ-032 SHALL cover: read addr 0x08, reg1 active with read data 0x1234_5678 and ready after 3 cycles -> response read data 0x1234_5678, status 00, o_register_valid high for 3+ cycles.
REQ-033 SHALL cover: read of an unmapped address (no active) -> status 11, data 0, one BUSY cycle.
REQ-034 SHALL cover: RGGEN_INITIATOR_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, active but never ready -> status 10 after 4 BUSY cycles; ready on the 4th cycle -> status 00.
REQ-035 SHALL cover: i_response_ready held low 5 cycles -> response payload stable, o_request_ready=0 throughout.
REQ-036 SHALL cover: i_rst_n asserted during BUSY -> o_register_valid=0 immediately, IDLE after release, next request completes normally.

Source files
------------

// File: rtl/rggen_register_initiator.sv
// Host-to-register bridge: accepts one request, broadcasts it to the register responders, returns a response.
// Optional BUSY timeout is compiled in with `define RGGEN_INITIATOR_TIMEOUT_EN.
module rggen_register_initiator #(
  parameter int ADDRESS_WIDTH  = 8,
  parameter int BUS_WIDTH      = 32,
  parameter int REGISTERS      = 1,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_request_valid,
  output logic                           o_request_ready,
  input  logic [1:0]                     i_request_access,
  input  logic [ADDRESS_WIDTH-1:0]       i_request_address,
  input  logic [BUS_WIDTH-1:0]           i_request_write_data,
  input  logic [BUS_WIDTH/8-1:0]         i_request_strobe,
  output logic                           o_response_valid,
  input  logic                           i_response_ready,
  output logic [1:0]                     o_response_status,
  output logic [BUS_WIDTH-1:0]           o_response_read_data,
  output logic                           o_register_valid,
  output logic [1:0]                     o_register_access,
  output logic [ADDRESS_WIDTH-1:0]       o_register_address,
  output logic [BUS_WIDTH-1:0]           o_register_write_data,
  output logic [BUS_WIDTH-1:0]           o_register_strobe,
  input  logic [REGISTERS-1:0]           i_register_active,
  input  logic [REGISTERS-1:0]           i_register_ready,
  input  logic [2*REGISTERS-1:0]         i_register_status,
  input  logic [BUS_WIDTH*REGISTERS-1:0] i_register_read_data
);

  localparam int STROBE_WIDTH = BUS_WIDTH / 8;

  if ((BUS_WIDTH % 8) != 0 || REGISTERS < 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("rggen_register_initiator: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY     = 2'd1,
    RESPONSE = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [1:0]                 access_q;
  logic [ADDRESS_WIDTH-1:0]   address_q;
  logic [BUS_WIDTH-1:0]       write_data_q;
  logic [STROBE_WIDTH-1:0]    strobe_q;
  logic [1:0]                 status_q, status_d;
  logic [BUS_WIDTH-1:0]       read_data_q, read_data_d;

  logic                       accept;
  logic                       finish;
  logic                       no_active;
  logic                       hit;
  logic                       timeout;
  logic [REGISTERS-1:0]       selected;
  logic [1:0]                 selected_status;
  logic [BUS_WIDTH-1:0]       selected_data;

  assign accept    = (state_q == IDLE) && i_request_valid;
  assign selected  = i_register_active & i_register_ready;
  assign no_active = ~|i_register_active;
  assign hit       = |selected;
  assign finish    = (state_q == BUSY) && (no_active || hit || timeout);

  // Responders are wired-OR: every selected entry contributes to the result.
  always_comb begin
    selected_status = '0;
    selected_data   = '0;
    for (int k = 0; k < REGISTERS; k++) begin
      if (selected[k]) begin
        selected_status = selected_status | i_register_status[2*k+:2];
        selected_data   = selected_data | i_register_read_data[BUS_WIDTH*k+:BUS_WIDTH];
      end
    end
  end

`ifdef RGGEN_INITIATOR_TIMEOUT_EN
  localparam int COUNT_WIDTH = $clog2(TIMEOUT_CYCLES);
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  assign timeout = (count_q == COUNT_WIDTH'(TIMEOUT_CYCLES - 1));

  always_comb begin
    count_d = '0;
    if ((state_q == BUSY) && !finish) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Decode error beats a responder hit, which beats a timeout in the same cycle.
  always_comb begin
    status_d    = status_q;
    read_data_d = read_data_q;
    if (finish) begin
      if (no_active) begin
        status_d    = 2'b11;
        read_data_d = '0;
      end else if (hit) begin
        status_d    = selected_status;
        read_data_d = access_q[0] ? '0 : selected_data;
      end else begin
        status_d    = 2'b10;
        read_data_d = '0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (accept) state_d = BUSY;
      BUSY:     if (finish) state_d = RESPONSE;
      RESPONSE: if (i_response_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    o_request_ready  = (state_q == IDLE);
    o_register_valid = (state_q == BUSY);
    o_response_valid = (state_q == RESPONSE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      access_q     <= '0;
      address_q    <= '0;
      write_data_q <= '0;
      strobe_q     <= '0;
      status_q     <= '0;
      read_data_q  <= '0;
    end else begin
      if (accept) begin
        access_q     <= i_request_access;
        address_q    <= i_request_address;
        write_data_q <= i_request_write_data;
        strobe_q     <= i_request_strobe;
      end
      status_q    <= status_d;
      read_data_q <= read_data_d;
    end
  end

  for (genvar gi = 0; gi < STROBE_WIDTH; gi++) begin : g_strobe
    assign o_register_strobe[8*gi+:8] = {8{strobe_q[gi]}};
  end

  assign o_register_access     = access_q;
  assign o_register_address    = address_q;
  assign o_register_write_data = write_data_q;
  assign o_response_status     = status_q;
  assign o_response_read_data  = read_data_q;

endmodule

// File: tb/tb_rggen_register_initiator.sv
// Self-checking bench for rggen_register_initiator: directed vector table, reset corner case, random traffic.
module tb_rggen_register_initiator;

  localparam int AW = 8;
  localparam int BW = 32;
  localparam int NR = 3;
  localparam int TO = 4;
`ifdef RGGEN_INITIATOR_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic             i_request_valid = 1'b0;
  logic             o_request_ready;
  logic [1:0]       i_request_access = '0;
  logic [AW-1:0]    i_request_address = '0;
  logic [BW-1:0]    i_request_write_data = '0;
  logic [BW/8-1:0]  i_request_strobe = '0;
  logic             o_response_valid;
  logic             i_response_ready = 1'b0;
  logic [1:0]       o_response_status;
  logic [BW-1:0]    o_response_read_data;
  logic             o_register_valid;
  logic [1:0]       o_register_access;
  logic [AW-1:0]    o_register_address;
  logic [BW-1:0]    o_register_write_data;
  logic [BW-1:0]    o_register_strobe;
  logic [NR-1:0]    i_register_active = '0;
  logic [NR-1:0]    i_register_ready = '0;
  logic [2*NR-1:0]  i_register_status = '0;
  logic [BW*NR-1:0] i_register_read_data = '0;

  int total = 0;
  int bad = 0;

  always #5 i_clk = ~i_clk;

  rggen_register_initiator #(
    .ADDRESS_WIDTH (AW),
    .BUS_WIDTH     (BW),
    .REGISTERS     (NR),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk                (i_clk),
    .i_rst_n              (i_rst_n),
    .i_request_valid      (i_request_valid),
    .o_request_ready      (o_request_ready),
    .i_request_access     (i_request_access),
    .i_request_address    (i_request_address),
    .i_request_write_data (i_request_write_data),
    .i_request_strobe     (i_request_strobe),
    .o_response_valid     (o_response_valid),
    .i_response_ready     (i_response_ready),
    .o_response_status    (o_response_status),
    .o_response_read_data (o_response_read_data),
    .o_register_valid     (o_register_valid),
    .o_register_access    (o_register_access),
    .o_register_address   (o_register_address),
    .o_register_write_data(o_register_write_data),
    .o_register_strobe    (o_register_strobe),
    .i_register_active    (i_register_active),
    .i_register_ready     (i_register_ready),
    .i_register_status    (i_register_status),
    .i_register_read_data (i_register_read_data)
  );

  typedef struct {
    logic [1:0]  access;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strobe;
    logic [2:0]  active;
    logic [2:0]  ready;
    int          ready_delay;
    int          resp_delay;
    logic [5:0]  status_all;
    logic [95:0] data_all;
    logic [1:0]  exp_status;
    logic [31:0] exp_data;
    int          exp_busy;
    logic [31:0] exp_strobe;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] access, input logic [7:0] addr, input logic [31:0] wdata,
                              input logic [3:0] strobe, input logic [2:0] active, input logic [2:0] ready,
                              input int ready_delay, input int resp_delay, input logic [5:0] status_all,
                              input logic [95:0] data_all, input logic [1:0] exp_status,
                              input logic [31:0] exp_data, input int exp_busy, input logic [31:0] exp_strobe);
    vec_t v;
    v.access = access; v.addr = addr; v.wdata = wdata; v.strobe = strobe;
    v.active = active; v.ready = ready; v.ready_delay = ready_delay; v.resp_delay = resp_delay;
    v.status_all = status_all; v.data_all = data_all;
    v.exp_status = exp_status; v.exp_data = exp_data; v.exp_busy = exp_busy; v.exp_strobe = exp_strobe;
    return v;
  endfunction

  // Reference model: what the bridge should answer, and after how many BUSY cycles.
  function automatic void model(inout vec_t v);
    int done_at;
    logic [1:0]  st;
    logic [31:0] rd;
    logic [31:0] sb;
    sb = 0;
    for (int b = 0; b < 4; b++) if (v.strobe[b]) sb = sb + (32'hFF << (8 * b));
    v.exp_strobe = sb;
    if (v.active == 0)                done_at = 1;
    else if ((v.active & v.ready) != 0) done_at = v.ready_delay + 1;
    else                              done_at = 1000000;
    st = 0;
    rd = 0;
    if (TO_EN && done_at > TO) begin
      st = 2'b10;
      done_at = TO;
    end else if (v.active == 0) begin
      st = 2'b11;
    end else begin
      for (int k = 0; k < NR; k++) begin
        if (v.active[k] && v.ready[k]) begin
          st = st | v.status_all[2*k+:2];
          rd = rd | v.data_all[32*k+:32];
        end
      end
      if (v.access[0]) rd = 0;
    end
    v.exp_status = st;
    v.exp_data = rd;
    v.exp_busy = done_at;
  endfunction

  task automatic run_txn(input vec_t v, input int idx);
    int k;
    @(negedge i_clk);
    chk("req_ready_idle", o_request_ready, 1);
    i_request_valid = 1'b1;
    i_request_access = v.access;
    i_request_address = v.addr;
    i_request_write_data = v.wdata;
    i_request_strobe = v.strobe;
    @(negedge i_clk);
    i_request_valid = 1'b0;
    i_request_write_data = ~v.wdata;
    i_request_address = ~v.addr;
    chk("reg_valid_first", o_register_valid, 1);
    chk("req_ready_busy", o_request_ready, 0);
    chk("reg_access", o_register_access, v.access);
    chk("reg_address", o_register_address, v.addr);
    chk("reg_wdata", o_register_write_data, v.wdata);
    chk("reg_strobe", o_register_strobe, v.exp_strobe);
    k = 0;
    while (o_register_valid && k < 64) begin
      k++;
      i_register_active = v.active;
      i_register_ready = (k > v.ready_delay) ? v.ready : 3'b000;
      i_register_status = v.status_all;
      i_register_read_data = v.data_all;
      @(negedge i_clk);
    end
    i_register_active = '0;
    i_register_ready = '0;
    i_register_status = '0;
    i_register_read_data = '0;
    chk("busy_cycles", k, v.exp_busy);
    chk("resp_valid", o_response_valid, 1);
    chk("resp_status", o_response_status, v.exp_status);
    chk("resp_data", o_response_read_data, v.exp_data);
    chk("req_ready_resp", o_request_ready, 0);
    for (int h = 0; h < v.resp_delay; h++) begin
      @(negedge i_clk);
      chk("hold_valid", o_response_valid, 1);
      chk("hold_status", o_response_status, v.exp_status);
      chk("hold_data", o_response_read_data, v.exp_data);
      chk("hold_req_ready", o_request_ready, 0);
    end
    i_response_ready = 1'b1;
    i_request_valid = 1'b1;
    @(negedge i_clk);
    i_response_ready = 1'b0;
    i_request_valid = 1'b0;
    chk("resp_valid_clear", o_response_valid, 0);
    chk("no_accept_at_resp", o_register_valid, 0);
    chk("req_ready_after", o_request_ready, 1);
    $display("txn %0d: acc=%0d addr=%h act=%b busy=%0d status=%0d data=%h", idx, v.access, v.addr,
             v.active, k, o_response_status, o_response_read_data);
  endtask

  vec_t tbl[$];
  vec_t v;

  initial begin
    tbl.push_back(mk(2'b01, 8'h04, 32'hA5A5_0000, 4'hC, 3'b001, 3'b001, 0, 0, 6'b00_00_00,
                     {32'h0, 32'h0, 32'hDEAD_BEEF}, 2'b00, 32'h0, 1, 32'hFFFF_0000));
    tbl.push_back(mk(2'b00, 8'h08, 32'h0, 4'h0, 3'b010, 3'b010, 3, 0, 6'b00_00_00,
                     {32'h0, 32'h1234_5678, 32'h0}, 2'b00, 32'h1234_5678, 4, 32'h0));
    tbl.push_back(mk(2'b00, 8'hF0, 32'h0, 4'hF, 3'b000, 3'b111, 0, 1, 6'b11_11_11,
                     {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, 2'b11, 32'h0, 1, 32'hFFFF_FFFF));
    tbl.push_back(mk(2'b00, 8'h20, 32'h0, 4'h1, 3'b100, 3'b100, 1, 5, 6'b01_00_00,
                     {32'hCAFE_F00D, 32'h0, 32'h0}, 2'b01, 32'hCAFE_F00D, 2, 32'h0000_00FF));
    tbl.push_back(mk(2'b00, 8'h0C, 32'h0, 4'h5, 3'b011, 3'b011, 0, 0, 6'b00_10_01,
                     {32'h0, 32'h00FF_0000, 32'h0000_FF00}, 2'b11, 32'h00FF_FF00, 1, 32'h00FF_00FF));
    tbl.push_back(mk(2'b00, 8'h10, 32'h0, 4'h2, 3'b011, 3'b001, 2, 2, 6'b00_10_00,
                     {32'h0, 32'h0000_2222, 32'h1111_0000}, 2'b00, 32'h1111_0000, 3, 32'h0000_FF00));
    tbl.push_back(mk(2'b11, 8'h14, 32'h0BAD_F00D, 4'h3, 3'b100, 3'b100, 0, 0, 6'b01_00_00,
                     {32'h7777_7777, 32'h0, 32'h0}, 2'b01, 32'h0, 1, 32'h0000_FFFF));
`ifdef RGGEN_INITIATOR_TIMEOUT_EN
    tbl.push_back(mk(2'b00, 8'h18, 32'h0, 4'h0, 3'b001, 3'b000, 0, 0, 6'b00_00_01,
                     {32'h0, 32'h0, 32'h5555_5555}, 2'b10, 32'h0, 4, 32'h0));
    tbl.push_back(mk(2'b00, 8'h1C, 32'h0, 4'h0, 3'b001, 3'b001, 3, 0, 6'b00_00_00,
                     {32'h0, 32'h0, 32'h6666_6666}, 2'b00, 32'h6666_6666, 4, 32'h0));
`endif

    // Reset state
    repeat (2) @(negedge i_clk);
    chk("rst_reg_valid", o_register_valid, 0);
    chk("rst_resp_valid", o_response_valid, 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("rst_req_ready", o_request_ready, 1);
    chk("rst_resp_status", o_response_status, 0);
    chk("rst_resp_data", o_response_read_data, 0);
    chk("rst_reg_address", o_register_address, 0);
    chk("rst_reg_strobe", o_register_strobe, 0);
    chk("rst_reg_wdata", o_register_write_data, 0);

    for (int i = 0; i < tbl.size(); i++) run_txn(tbl[i], i);

    // Reset asserted while BUSY abandons the transaction
    @(negedge i_clk);
    i_request_valid = 1'b1;
    i_request_access = 2'b00;
    i_request_address = 8'h40;
    i_request_strobe = 4'hF;
    @(negedge i_clk);
    i_request_valid = 1'b0;
    i_register_active = 3'b001;
    i_register_ready = 3'b000;
    chk("pre_rst_busy", o_register_valid, 1);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    chk("midrst_reg_valid", o_register_valid, 0);
    chk("midrst_resp_valid", o_response_valid, 0);
    chk("midrst_reg_address", o_register_address, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_register_active = '0;
    @(negedge i_clk);
    chk("postrst_req_ready", o_request_ready, 1);
    chk("postrst_resp_status", o_response_status, 0);
    run_txn(tbl[0], 100);

    // Random traffic against the reference model
    for (int i = 0; i < 40; i++) begin
      v.access = 2'($urandom_range(0, 3));
      v.addr = 8'($urandom);
      v.wdata = $urandom;
      v.strobe = 4'($urandom);
      v.active = 3'($urandom_range(0, 7));
      v.ready = 3'($urandom);
      if (v.active != 0 && (v.active & v.ready) == 0) v.ready = v.active;
      v.ready_delay = $urandom_range(0, 3);
      v.resp_delay = $urandom_range(0, 2);
      v.status_all = 6'($urandom);
      v.data_all = {$urandom, $urandom, $urandom};
      model(v);
      run_txn(v, 200 + i);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
